// File: rtl/light_safety_monitor.sv
// Registers the controller's lamp pattern to the drivers and checks it against the
// intersection safety rules. A violation latches a fault code and flashes red on both roads.
// Optional macro SAFETY_YELLOW_CHECK_EN adds the yellow-sequence checks (codes 5 and 6).
module light_safety_monitor #(
  parameter int FLASH_HALF = 16,
  parameter int MIN_YELLOW = 4,
  parameter int DARK_LIMIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       redMainIn,
  input  logic       yellowMainIn,
  input  logic       greenMainIn,
  input  logic       redSideIn,
  input  logic       yellowSideIn,
  input  logic       greenSideIn,
  input  logic       walkIn,
  input  logic       faultClear,
  output logic       redMain,
  output logic       yellowMain,
  output logic       greenMain,
  output logic       redSide,
  output logic       yellowSide,
  output logic       greenSide,
  output logic       walkLight,
  output logic       fault,
  output logic [2:0] faultCode
);

  localparam int DW = $clog2(DARK_LIMIT + 2);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  if (FLASH_HALF < 2 || MIN_YELLOW < 1 || DARK_LIMIT < 1) begin : gParamCheck
    $error("light_safety_monitor: FLASH_HALF >= 2, MIN_YELLOW >= 1, DARK_LIMIT >= 1 required");
  end

  typedef enum logic {PASS, FAULT} monState;

  monState       state, stateNext;
  logic [DW-1:0] darkCntMain, darkCntSide;
  logic [FW-1:0] flashCnt;
  logic          flashPhase, flashWrap;
  logic          darkMain, darkSide, goMain, goSide;
  logic [2:0]    staticCode, seqCode, passCode;
  logic          acceptIn, enterFault, leaveFault;

  assign darkMain  = !(redMainIn || yellowMainIn || greenMainIn);
  assign darkSide  = !(redSideIn || yellowSideIn || greenSideIn);
  assign goMain    = greenMainIn || yellowMainIn;
  assign goSide    = greenSideIn || yellowSideIn;
  assign flashWrap = (flashCnt == FW'(FLASH_HALF - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    staticCode = 3'd0;
    if (goMain && goSide)
      staticCode = 3'd1;
    else if (walkIn && (goMain || goSide))
      staticCode = 3'd2;
    else if ((redMainIn && yellowMainIn) || (redMainIn && greenMainIn) || (yellowMainIn && greenMainIn) ||
             (redSideIn && yellowSideIn) || (redSideIn && greenSideIn) || (yellowSideIn && greenSideIn))
      staticCode = 3'd3;
    else if ((darkMain && darkCntMain >= DW'(DARK_LIMIT)) || (darkSide && darkCntSide >= DW'(DARK_LIMIT)))
      staticCode = 3'd4;
  end

`ifdef SAFETY_YELLOW_CHECK_EN
  localparam int YW = $clog2(MIN_YELLOW + 1);

  logic          prevGreenMain, prevYellowMain, prevGreenSide, prevYellowSide;
  logic [YW-1:0] yellowCntMain, yellowCntSide;

  always_comb begin
    seqCode = 3'd0;
    if ((prevGreenMain && redMainIn) || (prevGreenSide && redSideIn))
      seqCode = 3'd5;
    else if ((prevYellowMain && redMainIn && yellowCntMain < YW'(MIN_YELLOW)) ||
             (prevYellowSide && redSideIn && yellowCntSide < YW'(MIN_YELLOW)))
      seqCode = 3'd6;
  end

  // Previous pattern and yellow run length only follow patterns that reached the lamps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevGreenMain  <= 1'b0;
      prevYellowMain <= 1'b0;
      prevGreenSide  <= 1'b0;
      prevYellowSide <= 1'b0;
      yellowCntMain  <= '0;
      yellowCntSide  <= '0;
    end else if (acceptIn || leaveFault) begin
      prevGreenMain  <= greenMainIn;
      prevYellowMain <= yellowMainIn;
      prevGreenSide  <= greenSideIn;
      prevYellowSide <= yellowSideIn;
      if (leaveFault) begin
        yellowCntMain <= '0;
        yellowCntSide <= '0;
      end else begin
        yellowCntMain <= !yellowMainIn ? '0 :
                         (yellowCntMain == YW'(MIN_YELLOW)) ? yellowCntMain : yellowCntMain + 1'b1;
        yellowCntSide <= !yellowSideIn ? '0 :
                         (yellowCntSide == YW'(MIN_YELLOW)) ? yellowCntSide : yellowCntSide + 1'b1;
      end
    end
  end
`else
  assign seqCode = 3'd0;
`endif

  assign passCode = (staticCode != 3'd0) ? staticCode : seqCode;

  always_comb begin
    stateNext  = state;
    acceptIn   = 1'b0;
    enterFault = 1'b0;
    leaveFault = 1'b0;
    case (state)
      PASS: begin
        if (passCode != 3'd0) begin
          stateNext  = FAULT;
          enterFault = 1'b1;
        end else begin
          acceptIn = 1'b1;
        end
      end
      FAULT: begin
        if (faultClear && staticCode == 3'd0) begin
          stateNext  = PASS;
          leaveFault = 1'b1;
        end
      end
      default: stateNext = PASS;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PASS;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      darkCntMain <= '0;
      darkCntSide <= '0;
    end else if (leaveFault) begin
      darkCntMain <= '0;
      darkCntSide <= '0;
    end else begin
      darkCntMain <= !darkMain ? '0 :
                     (darkCntMain == DW'(DARK_LIMIT + 1)) ? darkCntMain : darkCntMain + 1'b1;
      darkCntSide <= !darkSide ? '0 :
                     (darkCntSide == DW'(DARK_LIMIT + 1)) ? darkCntSide : darkCntSide + 1'b1;
    end
  end

  // NOTE: every register here has an explicit reset value; the lamps must come up red/red.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {redMain, yellowMain, greenMain} <= 3'b100;
      {redSide, yellowSide, greenSide} <= 3'b100;
      walkLight  <= 1'b0;
      fault      <= 1'b0;
      faultCode  <= 3'd0;
      flashCnt   <= '0;
      flashPhase <= 1'b1;
    end else if (acceptIn || leaveFault) begin
      {redMain, yellowMain, greenMain} <= {redMainIn, yellowMainIn, greenMainIn};
      {redSide, yellowSide, greenSide} <= {redSideIn, yellowSideIn, greenSideIn};
      walkLight  <= walkIn;
      fault      <= 1'b0;
      faultCode  <= 3'd0;
      flashCnt   <= '0;
      flashPhase <= 1'b1;
    end else if (enterFault) begin
      {redMain, yellowMain, greenMain} <= 3'b100;
      {redSide, yellowSide, greenSide} <= 3'b100;
      walkLight  <= 1'b0;
      fault      <= 1'b1;
      faultCode  <= passCode;
      flashCnt   <= '0;
      flashPhase <= 1'b1;
    end else if (state == FAULT) begin
      // Lamps track the phase value being written this edge so the flash has no extra lag.
      flashCnt   <= flashWrap ? '0 : flashCnt + 1'b1;
      flashPhase <= flashPhase ^ flashWrap;
      {redMain, yellowMain, greenMain} <= {flashPhase ^ flashWrap, 2'b00};
      {redSide, yellowSide, greenSide} <= {flashPhase ^ flashWrap, 2'b00};
      walkLight  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_light_safety_monitor.sv
// Self-checking bench for light_safety_monitor: directed steps plus randomized patterns,
// all compared against a rule-level model of the safety monitor kept in this file.
module tb_light_safety_monitor;

  localparam int FLASH_HALF = 16;
  localparam int MIN_YELLOW = 4;
  localparam int DARK_LIMIT = 2;

  // Direction lamp codes {red, yellow, green}.
  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LD = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic       redMainIn, yellowMainIn, greenMainIn;
  logic       redSideIn, yellowSideIn, greenSideIn;
  logic       walkIn, faultClear;
  logic       redMain, yellowMain, greenMain;
  logic       redSide, yellowSide, greenSide;
  logic       walkLight, fault;
  logic [2:0] faultCode;

  always #5 clk = ~clk;

  light_safety_monitor #(
    .FLASH_HALF(FLASH_HALF),
    .MIN_YELLOW(MIN_YELLOW),
    .DARK_LIMIT(DARK_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .redMainIn(redMainIn), .yellowMainIn(yellowMainIn), .greenMainIn(greenMainIn),
    .redSideIn(redSideIn), .yellowSideIn(yellowSideIn), .greenSideIn(greenSideIn),
    .walkIn(walkIn), .faultClear(faultClear),
    .redMain(redMain), .yellowMain(yellowMain), .greenMain(greenMain),
    .redSide(redSide), .yellowSide(yellowSide), .greenSide(greenSide),
    .walkLight(walkLight), .fault(fault), .faultCode(faultCode)
  );

  int checks = 0;
  int errors = 0;

  // Reference model; patterns are {walk, side{r,y,g}, main{r,y,g}}.
  logic       mFault;
  logic [6:0] mOut;
  logic [6:0] mPrev;
  int         mCode, mSince, mDarkM, mDarkS, mYelM, mYelS;

  function automatic logic [6:0] mkPat(input logic [2:0] m, input logic [2:0] s, input logic w);
    return {w, s, m};
  endfunction

  task automatic modelReset();
    mFault = 1'b0;
    mOut   = {1'b0, LR, LR};
    mPrev  = {1'b0, LR, LR};
    mCode  = 0;
    mSince = 0;
    mDarkM = 0;
    mDarkS = 0;
    mYelM  = 0;
    mYelS  = 0;
  endtask

  function automatic int staticRule(input logic [6:0] p);
    logic [2:0] m = p[2:0];
    logic [2:0] s = p[5:3];
    bit goM = m[0] || m[1];
    bit goS = s[0] || s[1];
    if (goM && goS) return 1;
    if (p[6] && (goM || goS)) return 2;
    if ($countones(m) > 1 || $countones(s) > 1) return 3;
    if ((m == LD && mDarkM + 1 > DARK_LIMIT) || (s == LD && mDarkS + 1 > DARK_LIMIT)) return 4;
    return 0;
  endfunction

  function automatic int seqRule(input logic [6:0] p);
`ifdef SAFETY_YELLOW_CHECK_EN
    if ((mPrev[0] && p[2]) || (mPrev[3] && p[5])) return 5;
    if ((mPrev[1] && p[2] && mYelM < MIN_YELLOW) || (mPrev[4] && p[5] && mYelS < MIN_YELLOW)) return 6;
`endif
    return (p[6] === 1'bx) ? 7 : 0;
  endfunction

  task automatic modelStep(input logic [6:0] p, input logic clr);
    int  sc = staticRule(p);
    int  code;
    bit  leaving = 1'b0;
    bit  phase;
    if (!mFault) begin
      code = (sc != 0) ? sc : seqRule(p);
      if (code != 0) begin
        mFault = 1'b1;
        mCode  = code;
        mSince = 0;
        mOut   = {1'b0, LR, LR};
      end else begin
        mOut  = p;
        mPrev = p;
        mYelM = p[1] ? mYelM + 1 : 0;
        mYelS = p[4] ? mYelS + 1 : 0;
      end
    end else if (clr && sc == 0) begin
      leaving = 1'b1;
      mFault  = 1'b0;
      mCode   = 0;
      mOut    = p;
      mPrev   = p;
      mYelM   = 0;
      mYelS   = 0;
    end else begin
      mSince++;
      phase = ((mSince / FLASH_HALF) % 2) == 0;
      mOut  = {1'b0, phase, 2'b00, phase, 2'b00};
    end
    mDarkM = (leaving || p[2:0] != LD) ? 0 : mDarkM + 1;
    mDarkS = (leaving || p[5:3] != LD) ? 0 : mDarkS + 1;
  endtask

  task automatic checkOut(input string tag);
    logic [6:0] obs = {walkLight, redSide, yellowSide, greenSide, redMain, yellowMain, greenMain};
    checks++;
    assert (obs === mOut) else begin
      errors++;
      $error("FAIL %s lamps observed=%b expected=%b", tag, obs, mOut);
    end
    checks++;
    assert (fault === mFault) else begin
      errors++;
      $error("FAIL %s fault observed=%b expected=%b", tag, fault, mFault);
    end
    checks++;
    assert (faultCode === 3'(mCode)) else begin
      errors++;
      $error("FAIL %s faultCode observed=%0d expected=%0d", tag, faultCode, mCode);
    end
  endtask

  task automatic cycle(input logic [6:0] p, input logic clr, input string tag);
    {walkIn, redSideIn, yellowSideIn, greenSideIn, redMainIn, yellowMainIn, greenMainIn} = p;
    faultClear = clr;
    modelStep(p, clr);
    @(posedge clk);
    #1;
    checkOut(tag);
  endtask

  task automatic runPat(input logic [6:0] p, input logic clr, input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(p, clr, tag);
  endtask

  function automatic logic [6:0] legalPick();
    case ($urandom_range(5))
      0:       return mkPat(LG, LR, 1'b0);
      1:       return mkPat(LY, LR, 1'b0);
      2:       return mkPat(LR, LG, 1'b0);
      3:       return mkPat(LR, LY, 1'b0);
      4:       return mkPat(LR, LR, 1'b1);
      default: return mkPat(LR, LR, 1'b0);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] cur;
    reset = 1'b1;
    {walkIn, redSideIn, yellowSideIn, greenSideIn, redMainIn, yellowMainIn, greenMainIn} = mkPat(LR, LR, 1'b0);
    faultClear = 1'b0;
    #1 reset = 1'b0;
    modelReset();
    #2 checkOut("reset");
    @(negedge clk);
    reset = 1'b1;

    // Legal sequence: outputs follow inputs one cycle later.
    runPat(mkPat(LG, LR, 1'b0), 1'b0, 5, "legal mainG");
    runPat(mkPat(LY, LR, 1'b0), 1'b0, 4, "legal mainY");
    runPat(mkPat(LR, LR, 1'b1), 1'b0, 2, "legal walk");
    runPat(mkPat(LR, LG, 1'b0), 1'b0, 4, "legal sideG");
    runPat(mkPat(LR, LY, 1'b0), 1'b0, 4, "legal sideY");
    runPat(mkPat(LR, LR, 1'b0), 1'b0, 2, "legal allR");

    // Conflicting greens, then a full flash period and a clean clear.
    cycle(mkPat(LG, LG, 1'b0), 1'b0, "conflict");
    runPat(mkPat(LR, LR, 1'b0), 1'b0, 40, "flash");
    cycle(mkPat(LR, LR, 1'b0), 1'b1, "clear1");

    // Walk with green; clear refused while still illegal.
    cycle(mkPat(LG, LR, 1'b1), 1'b0, "walkGreen");
    runPat(mkPat(LG, LR, 1'b1), 1'b1, 3, "clearIllegal");
    cycle(mkPat(LR, LR, 1'b0), 1'b1, "clear2");

    // Dark main road: three cycles faults, two do not.
    runPat(mkPat(LD, LR, 1'b0), 1'b0, 3, "dark3");
    cycle(mkPat(LR, LR, 1'b0), 1'b1, "clear4");
    runPat(mkPat(LD, LR, 1'b0), 1'b0, 2, "dark2");
    cycle(mkPat(LR, LR, 1'b0), 1'b0, "darkEnd");

    // Short yellow and skipped yellow; clears also exercise faultClear in PASS.
    runPat(mkPat(LG, LR, 1'b0), 1'b0, 2, "shortY green");
    runPat(mkPat(LY, LR, 1'b0), 1'b0, 2, "shortY yellow");
    cycle(mkPat(LR, LR, 1'b0), 1'b0, "shortY red");
    runPat(mkPat(LR, LR, 1'b0), 1'b1, 2, "clear6");
    cycle(mkPat(LG, LR, 1'b0), 1'b0, "skipY green");
    cycle(mkPat(LR, LR, 1'b0), 1'b0, "skipY red");
    runPat(mkPat(LR, LR, 1'b0), 1'b1, 2, "clear5");

    // Asynchronous reset between edges while flashing.
    cycle(mkPat(LG, LG, 1'b0), 1'b0, "preReset");
    runPat(mkPat(LR, LR, 1'b0), 1'b0, 20, "midFlash");
    #3 reset = 1'b0;
    modelReset();
    #1 checkOut("asyncReset");
    #1 reset = 1'b1;
    runPat(mkPat(LG, LR, 1'b0), 1'b0, 3, "postReset");

    // Randomized traffic: sticky patterns, legal jumps, raw noise and random clears.
    cur = mkPat(LG, LR, 1'b0);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(99);
      if (r < 15)      cur = 7'($urandom);
      else if (r < 45) cur = legalPick();
      cycle(cur, ($urandom_range(3) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
